// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: framebuffer word FIFO, pixel unpack (RGB332/444/555/565),
// channel expansion, colour-bar test pattern and a single output register
// that keeps colour aligned with the delayed hsync/vsync/DE.
module vga_pixel_pipe #(
    parameter int BUS_WIDTH  = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int CH_WIDTH   = 8,
    parameter int POS_WIDTH  = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 test_i,
    input  logic [1:0]           mode_i,
    input  logic [POS_WIDTH-1:0] hvlen_i,
    input  logic                 pclk_en_i,
    input  logic                 de_i,
    input  logic                 hsync_i,
    input  logic                 vsync_i,
    input  logic [POS_WIDTH-1:0] pos_x_i,
    input  logic                 frame_start_i,
    input  logic                 pixel_valid_i,
    output logic                 pixel_ready_o,
    input  logic [BUS_WIDTH-1:0] pixel_data_i,
    input  logic                 clr_i,
    output logic [CH_WIDTH-1:0]  vga_r_o,
    output logic [CH_WIDTH-1:0]  vga_g_o,
    output logic [CH_WIDTH-1:0]  vga_b_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic                 underflow_o
);

    localparam int PPW8   = BUS_WIDTH / 8;
    localparam int PPW16  = BUS_WIDTH / 16;
    localparam int SLOT_W = $clog2(PPW8);
    localparam int AW     = $clog2(FIFO_DEPTH);

    // Channel expansion: replicate the field MSB-first and keep the top bits.
    function automatic logic [CH_WIDTH-1:0] exp2(input logic [1:0] v);
        logic [2*CH_WIDTH-1:0] t;
        t = {CH_WIDTH{v}};
        return t[2*CH_WIDTH-1 -: CH_WIDTH];
    endfunction

    function automatic logic [CH_WIDTH-1:0] exp3(input logic [2:0] v);
        logic [3*CH_WIDTH-1:0] t;
        t = {CH_WIDTH{v}};
        return t[3*CH_WIDTH-1 -: CH_WIDTH];
    endfunction

    function automatic logic [CH_WIDTH-1:0] exp4(input logic [3:0] v);
        logic [4*CH_WIDTH-1:0] t;
        t = {CH_WIDTH{v}};
        return t[4*CH_WIDTH-1 -: CH_WIDTH];
    endfunction

    function automatic logic [CH_WIDTH-1:0] exp5(input logic [4:0] v);
        logic [5*CH_WIDTH-1:0] t;
        t = {CH_WIDTH{v}};
        return t[5*CH_WIDTH-1 -: CH_WIDTH];
    endfunction

    function automatic logic [CH_WIDTH-1:0] exp6(input logic [5:0] v);
        logic [6*CH_WIDTH-1:0] t;
        t = {CH_WIDTH{v}};
        return t[6*CH_WIDTH-1 -: CH_WIDTH];
    endfunction

    // State
    logic [BUS_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [SLOT_W-1:0]    r_slot;
    logic [1:0]           r_mode;
    logic                 r_underflow;
    logic [CH_WIDTH-1:0]  r_red;
    logic [CH_WIDTH-1:0]  r_grn;
    logic [CH_WIDTH-1:0]  r_blu;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_de;

    // Control
    logic                 w_empty;
    logic                 w_full;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_adv;
    logic                 w_fetch;
    logic                 w_last;
    logic                 w_pop;
    logic                 w_uf_set;

    // Datapath
    logic [BUS_WIDTH-1:0] w_head;
    logic [7:0]           w_pix8_arr  [PPW8];
    logic [15:0]          w_pix16_arr [PPW16];
    logic [7:0]           w_pix8;
    logic [15:0]          w_pix16;
    logic [CH_WIDTH-1:0]  w_fb_r;
    logic [CH_WIDTH-1:0]  w_fb_g;
    logic [CH_WIDTH-1:0]  w_fb_b;

    // Test pattern
    logic [POS_WIDTH-1:0] w_bar_w;
    logic [6:0]           w_ge;
    logic [2:0]           w_bar;
    logic [CH_WIDTH-1:0]  w_tp_r;
    logic [CH_WIDTH-1:0]  w_tp_g;
    logic [CH_WIDTH-1:0]  w_tp_b;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
    // frame_start blocks the push so a flushed FIFO cannot take a stale word.
    assign w_ready  = en_i & ~test_i & ~w_full & ~frame_start_i;
    assign w_push   = pixel_valid_i & w_ready;
    assign w_adv    = pclk_en_i & de_i & en_i & ~test_i;
    assign w_fetch  = w_adv & ~w_empty;
    assign w_uf_set = w_adv & w_empty;
    assign w_last   = (r_mode == 2'b00) ? (r_slot == SLOT_W'(PPW8 - 1))
                                        : (r_slot == SLOT_W'(PPW16 - 1));
    assign w_pop    = w_fetch & w_last;

    assign w_head   = r_mem[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < PPW8; gi++) begin : g_pix8
            assign w_pix8_arr[gi] = w_head[gi*8 +: 8];
        end
        for (genvar gi = 0; gi < PPW16; gi++) begin : g_pix16
            assign w_pix16_arr[gi] = w_head[gi*16 +: 16];
        end
    endgenerate

    // In 16 bpp modes the slot never exceeds PPW16-1, so its top bit is zero.
    assign w_pix8  = w_pix8_arr[r_slot];
    assign w_pix16 = w_pix16_arr[r_slot[SLOT_W-2:0]];

    // Field extraction and expansion for the latched pixel format
    always_comb begin
        w_fb_r = '0;
        w_fb_g = '0;
        w_fb_b = '0;
        case (r_mode)
            2'b00: begin
                w_fb_r = exp3(w_pix8[7:5]);
                w_fb_g = exp3(w_pix8[4:2]);
                w_fb_b = exp2(w_pix8[1:0]);
            end
            2'b01: begin
                w_fb_r = exp4(w_pix16[11:8]);
                w_fb_g = exp4(w_pix16[7:4]);
                w_fb_b = exp4(w_pix16[3:0]);
            end
            2'b10: begin
                w_fb_r = exp5(w_pix16[14:10]);
                w_fb_g = exp5(w_pix16[9:5]);
                w_fb_b = exp5(w_pix16[4:0]);
            end
            default: begin
                w_fb_r = exp5(w_pix16[15:11]);
                w_fb_g = exp6(w_pix16[10:5]);
                w_fb_b = exp5(w_pix16[4:0]);
            end
        endcase
    end

    // Bar boundaries are k*(hvlen/8); the bar index is the number passed.
    assign w_bar_w = hvlen_i >> 3;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_bar_thr
            logic [POS_WIDTH+2:0] w_thr;
            assign w_thr    = {3'b000, w_bar_w} * (POS_WIDTH+3)'(gi + 1);
            assign w_ge[gi] = ({3'b000, pos_x_i} >= w_thr);
        end
    endgenerate

    // Thresholds are non-decreasing, so the highest one passed gives the bar.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (w_ge[k]) begin
                w_bar = 3'(k + 1);
            end
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black.
    assign w_tp_r = {CH_WIDTH{~w_bar[1]}};
    assign w_tp_g = {CH_WIDTH{~w_bar[2]}};
    assign w_tp_b = {CH_WIDTH{~w_bar[0]}};

    // Word storage; write side only, head word is read by the pointer
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pixel_data_i;
        end
    end

    // FIFO pointers, occupancy and slot index; frame_start flushes all
    always_ff @(posedge clk_i) begin
        if (rst_i || frame_start_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_slot   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_fetch) begin
                r_slot <= w_last ? '0 : r_slot + SLOT_W'(1);
            end
        end
    end

    // Pixel format is only taken while the block is disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode <= 2'b00;
        end else if (!en_i) begin
            r_mode <= mode_i;
        end
    end

    // Sticky underflow; a new underflow beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (clr_i) begin
            r_underflow <= 1'b0;
        end
    end

    // Output register: colour and timing captured together on each strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_red   <= '0;
            r_grn   <= '0;
            r_blu   <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
            r_de    <= 1'b0;
        end else if (pclk_en_i) begin
            r_hsync <= en_i & hsync_i;
            r_vsync <= en_i & vsync_i;
            r_de    <= en_i & de_i;
            if (!en_i || !de_i) begin
                r_red <= '0;
                r_grn <= '0;
                r_blu <= '0;
            end else if (test_i) begin
                r_red <= w_tp_r;
                r_grn <= w_tp_g;
                r_blu <= w_tp_b;
            end else if (w_empty) begin
                r_red <= '0;
                r_grn <= '0;
                r_blu <= '0;
            end else begin
                r_red <= w_fb_r;
                r_grn <= w_fb_g;
                r_blu <= w_fb_b;
            end
        end
    end

    assign pixel_ready_o = w_ready;
    assign vga_r_o       = r_red;
    assign vga_g_o       = r_grn;
    assign vga_b_o       = r_blu;
    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign de_o          = r_de;
    assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe (BUS_WIDTH=64, CH_WIDTH=8).
module tb_vga_pixel_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        test_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic [11:0] hvlen_i = 12'd640;
    logic        pclk_en = 1'b0;
    logic        de_i = 1'b0;
    logic        hsync_i = 1'b0;
    logic        vsync_i = 1'b0;
    logic [11:0] pos_x_i = '0;
    logic        frame_start_i = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [63:0] pixel_data = '0;
    logic        clr_i = 1'b0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync_o, vsync_o, de_o, underflow_o;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [63:0] m_q[$];
    int          m_slot = 0;
    int          m_mode = 0;
    logic        m_uf   = 1'b0;
    logic [27:0] sb[$];

    vga_pixel_pipe #(
        .BUS_WIDTH(64), .FIFO_DEPTH(2), .CH_WIDTH(8), .POS_WIDTH(12)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en_i), .test_i(test_i), .mode_i(mode_i),
        .hvlen_i(hvlen_i), .pclk_en_i(pclk_en), .de_i(de_i), .hsync_i(hsync_i),
        .vsync_i(vsync_i), .pos_x_i(pos_x_i), .frame_start_i(frame_start_i),
        .pixel_valid_i(pixel_valid), .pixel_ready_o(pixel_ready),
        .pixel_data_i(pixel_data), .clr_i(clr_i), .vga_r_o(vga_r),
        .vga_g_o(vga_g), .vga_b_o(vga_b), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .de_o(de_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Bit-by-bit replication: output bit i (from MSB) is field bit w-1-(i mod w)
    function automatic logic [7:0] ex(input int v, input int w);
        logic [7:0] res;
        for (int i = 0; i < 8; i++) begin
            res[7-i] = 1'((v >> (w - 1 - (i % w))) & 1);
        end
        return res;
    endfunction

    function automatic logic [23:0] model_pix(input logic [63:0] w, input int slot, input int mode);
        logic [63:0] t;
        int p;
        if (mode == 0) begin
            t = w >> (slot * 8);
            p = int'(t[7:0]);
            return {ex((p >> 5) & 7, 3), ex((p >> 2) & 7, 3), ex(p & 3, 2)};
        end
        t = w >> (slot * 16);
        p = int'(t[15:0]);
        case (mode)
            1:       return {ex((p >> 8) & 15, 4), ex((p >> 4) & 15, 4), ex(p & 15, 4)};
            2:       return {ex((p >> 10) & 31, 5), ex((p >> 5) & 31, 5), ex(p & 31, 5)};
            default: return {ex((p >> 11) & 31, 5), ex((p >> 5) & 63, 6), ex(p & 31, 5)};
        endcase
    endfunction

    function automatic logic [23:0] bar_model(input int px, input int hv);
        int bw;
        int idx;
        bw  = hv / 8;
        idx = (bw == 0) ? 7 : px / bw;
        if (idx > 7) idx = 7;
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // One pixel strobe; the expected output is queued as it is driven
    task automatic strobe(input logic de, input logic hs, input logic vs, input int px);
        logic [23:0] col;
        logic        set;
        int          ppw;
        @(negedge clk);
        pclk_en = 1'b1;
        de_i    = de;
        hsync_i = hs;
        vsync_i = vs;
        pos_x_i = 12'(px);
        col = '0;
        set = 1'b0;
        if (de && en_i) begin
            if (test_i) begin
                col = bar_model(px, int'(hvlen_i));
            end else if (m_q.size() == 0) begin
                set = 1'b1;
            end else begin
                col = model_pix(m_q[0], m_slot, m_mode);
                ppw = (m_mode == 0) ? 8 : 4;
                m_slot++;
                if (m_slot == ppw) begin
                    m_slot = 0;
                    void'(m_q.pop_front());
                end
            end
        end
        if (set) m_uf = 1'b1;
        else if (clr_i) m_uf = 1'b0;
        sb.push_back({m_uf, en_i & de, en_i & hs, en_i & vs, col});
        @(posedge clk);
        #1;
        pclk_en = 1'b0;
        de_i    = 1'b0;
        hsync_i = 1'b0;
        vsync_i = 1'b0;
    endtask

    task automatic push(input logic [63:0] w);
        logic exp_rdy;
        @(negedge clk);
        pixel_valid = 1'b1;
        pixel_data  = w;
        #1;
        exp_rdy = en_i && !test_i && !frame_start_i && (m_q.size() < 2);
        chk("push_ready", 64'(pixel_ready), 64'(exp_rdy));
        @(posedge clk);
        if (exp_rdy) m_q.push_back(w);
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        @(negedge clk);
        #1;
        chk(tag, 64'(pixel_ready), 64'(exp));
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        m_uf  = 1'b0;
        chk("uf_after_clr", 64'(underflow_o), 64'(m_uf));
    endtask

    // Mode is taken during a disabled cycle; a later change while enabled is ignored
    task automatic set_mode(input int m);
        @(negedge clk);
        en_i   = 1'b0;
        mode_i = 2'(m);
        @(posedge clk);
        #1;
        en_i   = 1'b1;
        m_mode = m;
        mode_i = ~2'(m);
    endtask

    // Output monitor: compare one clk after every strobe
    always @(posedge clk) begin
        if (pclk_en && !rst) begin
            #1;
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL pix: output with no expected entry");
            end else begin
                chk("pix", 64'({underflow_o, de_o, hsync_o, vsync_o, vga_r, vga_g, vga_b}),
                    64'(sb.pop_front()));
            end
        end
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out", 64'({underflow_o, de_o, hsync_o, vsync_o, vga_r, vga_g, vga_b}), 64'(0));
        chk("rst_ready_en0", 64'(pixel_ready), 64'(0));
        en_i = 1'b1;
        #1;
        chk("rst_ready_en1", 64'(pixel_ready), 64'(1));

        // RGB565 word, then underflow behaviour on the emptied FIFO
        set_mode(3);
        push(64'h001F_07E0_F800_FFFF);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'(i & 1), 1'(i == 0), i);
        chk("uf_t1", 64'(underflow_o), 64'(0));
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b0, 10 + i);
        chk("uf_set", 64'(underflow_o), 64'(1));
        clr_pulse();
        clr_i = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, 20);
        clr_i = 1'b0;
        chk("uf_set_wins", 64'(underflow_o), 64'(1));
        clr_pulse();

        // RGB332: eight pixels per word, pop only after the last
        set_mode(0);
        push(64'h8040_2010_FF03_1CE0);
        push(64'h0123_4567_89AB_CDEF);
        push(64'hDEAD_BEEF_DEAD_BEEF);
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b0, i);
        chk_ready("rdy_full_7px", 1'b0);
        strobe(1'b1, 1'b0, 1'b0, 7);
        chk_ready("rdy_after_8px", 1'b1);
        for (int i = 0; i < 8; i++) strobe(1'(i != 3), 1'b0, 1'b1, i);
        strobe(1'b1, 1'b0, 1'b0, 9);
        clr_pulse();

        // RGB555 with frame_start flush mid-word
        set_mode(2);
        push(64'h7FFF_7C00_03E0_001F);
        push(64'h1234_5678_1357_2468);
        strobe(1'b1, 1'b0, 1'b0, 0);
        strobe(1'b1, 1'b0, 1'b0, 1);
        @(negedge clk);
        frame_start_i = 1'b1;
        pixel_valid   = 1'b1;
        pixel_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("fs_ready", 64'(pixel_ready), 64'(0));
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        pixel_valid   = 1'b0;
        m_q.delete();
        m_slot = 0;
        chk("uf_fs_unaffected", 64'(underflow_o), 64'(0));
        strobe(1'b1, 1'b0, 1'b0, 2);
        clr_pulse();
        push(64'h0000_0000_4210_7C1F);
        strobe(1'b1, 1'b0, 1'b0, 0);
        strobe(1'b1, 1'b0, 1'b0, 1);

        // Colour-bar test mode
        @(negedge clk);
        test_i  = 1'b1;
        hvlen_i = 12'd640;
        foreach (sb[i]) begin end
        begin
            int xs[5] = '{0, 80, 559, 560, 700};
            for (int i = 0; i < 5; i++) begin
                strobe(1'b1, 1'b0, 1'b0, xs[i]);
                chk_ready("tp_ready", 1'b0);
            end
        end
        strobe(1'b0, 1'b1, 1'b0, 100);
        push(64'h1111_2222_3333_4444);
        @(negedge clk);
        test_i = 1'b0;

        // RGB444 on the leftover word, then reset mid-line
        set_mode(1);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b0, i);
        push(64'h0ABC_0F00_00F0_000F);
        push(64'h0123_0456_0789_0FFF);
        strobe(1'b1, 1'b0, 1'b0, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_q.delete();
        m_slot = 0;
        m_mode = 0;
        m_uf   = 1'b0;
        chk("rst_mid_out", 64'({underflow_o, de_o, hsync_o, vsync_o, vga_r, vga_g, vga_b}), 64'(0));
        chk("rst_mid_ready", 64'(pixel_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        push(64'h0000_0000_0000_03E0);
        strobe(1'b1, 1'b1, 1'b1, 0);
        strobe(1'b1, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_pixel_pipe.md
Name: vga_pixel_pipe

Overview:
- Parametrised successor to the fixed 64-bit VGA pixel path.
- Accepts framebuffer words of configurable width through a valid/ready port and buffers them in a small word FIFO.
- Unpacks 8 bpp or 16 bpp pixels, expands each colour channel to a configurable output width, and emits one pixel per pixel-clock enable, aligned with the delayed sync/DE.
- Sits between the DMA/framebuffer reader and the VGA pins. Timing (pclk_en, de, syncs, pos_x) comes from the existing timing generator. Adds underflow detection, per-frame resync and a built-in colour-bar test mode.

Parameters:
- BUS_WIDTH, 64: framebuffer word width; must be 32, 64 or 128.
- FIFO_DEPTH, 2: word FIFO entries; power of two, ≥2.
- CH_WIDTH, 8: width of each output colour channel; 6..10.
- POS_WIDTH, 12: width of pos_x_i and hvlen_i.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  block enable
- test_i  in  1  1 = colour-bar test pattern, 0 = framebuffer
- mode_i  in  2  00 RGB332, 01 RGB444, 10 RGB555, 11 RGB565
- hvlen_i  in  POS_WIDTH  visible line length in pixels
- pclk_en_i  in  1  pixel-clock enable strobe
- de_i  in  1  data enable from timing generator
- hsync_i  in  1  hsync from timing generator
- vsync_i  in  1  vsync from timing generator
- pos_x_i  in  POS_WIDTH  visible x position
- frame_start_i  in  1  one-cycle pulse at frame end/start
- pixel_valid_i  in  1  framebuffer word valid
- pixel_ready_o  out  1  framebuffer word ready
- pixel_data_i  in  BUS_WIDTH  framebuffer word
- clr_i  in  1  clears underflow_o
- vga_r_o  out  CH_WIDTH  red
- vga_g_o  out  CH_WIDTH  green
- vga_b_o  out  CH_WIDTH  blue
- hsync_o  out  1  delayed hsync
- vsync_o  out  1  delayed vsync
- de_o  out  1  delayed DE
- underflow_o  out  1  sticky underflow flag

Behaviour:
- Reset (rst_i=1 at clk edge): FIFO empty, slot index 0, all colour outputs 0, hsync_o/vsync_o/de_o 0, underflow_o 0, latched mode 00.
- Mode latch: mode_i is latched on every cycle with en_i=0. Changes to mode_i while en_i=1 are ignored.
- Pixels per word (PPW): BUS_WIDTH/8 for RGB332, BUS_WIDTH/16 otherwise. Pixel k occupies bits [k*bpp +: bpp], lowest pixel first.
- 16 bpp field positions:
  - RGB444 uses [11:0]: R[11:8] G[7:4] B[3:0].
  - RGB555 uses [14:0]: R[14:10] G[9:5] B[4:0].
  - RGB565: R[15:11] G[10:5] B[4:0].
- 8 bpp field positions (RGB332): R[7:5] G[4:2] B[1:0].
- Channel expansion: w-bit value v is replicated MSB-first until CH_WIDTH bits are filled, then truncated. Examples at CH_WIDTH=8: 5'h1F→8'hFF, 2'b10→8'hAA, 0→0.
- Push side:
  - pixel_ready_o = en_i & ~test_i & ~fifo_full & ~frame_start_i.
  - Push on pixel_valid_i & pixel_ready_o.
- Advance: adv = pclk_en_i & de_i & en_i & ~test_i.
  - adv with FIFO non-empty: output pixel[slot] of the head word. If slot==PPW-1, pop the head and set slot=0; else slot+1.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - adv with FIFO empty: output 0, set underflow_o, slot unchanged.
- underflow_o: sticky; cleared by clr_i. If set and clear occur in the same cycle, set wins.
- frame_start_i: flushes the FIFO and sets slot=0 at the next edge. No push is possible in that cycle. underflow_o is unaffected.
- Test mode:
  - Bar index = pos_x_i / (hvlen_i>>3), computed with a comparator chain (no divider), saturating at 7.
  - Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black, each channel at all-ones or 0.
  - FIFO is not consumed; pixel_ready_o=0.
- Output register:
  - Updates only on pclk_en_i cycles; holds between strobes.
  - Latency: one clk after the pclk_en_i cycle. hsync_o, vsync_o and de_o pass through the same register, so they stay aligned with colour.
  - Colour is forced to 0 when de_i=0 or en_i=0.
- en_i=0: FIFO and slot state hold; pixel_ready_o=0; outputs go to 0 at the next pclk_en_i.

Test Plan:
1. BUS_WIDTH=64, CH_WIDTH=8, RGB565; push 64'h001F_07E0_F800_FFFF; 4 pclk strobes with de=1 → (FF,FF,FF), (FF,00,00), (00,FF,00), (00,00,FF), each one clk after its strobe; pop after the 4th; de_o aligned.
2. RGB332; push a word with low bytes E0,1C,03 → r=FF, g=FF, b=FF respectively on pixels 0..2; the word pops only after 8 pixels.
3. FIFO empty; 3 strobes with de=1 → colour 0, underflow_o=1 and held; clr_i pulse → 0; set and clr_i in the same cycle → remains 1.
4. FIFO full (2 words), 2 pixels of word 0 consumed; frame_start_i pulse → pixel_ready_o=0 that cycle, FIFO empty; next pushed word outputs from pixel 0.
5. test_i=1, hvlen=640: pos_x 0→white, 80→yellow, 559→blue, 560→black, 700→black; pixel_ready_o=0 throughout.
6. Reset mid-line with FIFO full and underflow set → next cycle: outputs 0, underflow_o=0, FIFO empty, pixel_ready_o=1 given en_i=1, test_i=0.
